// File: rtl/tc141_pkg.sv
// tc141_pkg: definitions shared by the tc141 pulse-accumulator slice.
//   state_t : FSM state encoding for the accumulator control
//   CW_DEF  : default pulse-count width
//   TW_DEF  : default window-timer width
package tc141_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam int CW_DEF = 8;
    localparam int TW_DEF = 16;

endpackage

// File: rtl/tc141_fflopx.sv
// tc141_fflopx: generic register cell. Every flop in the tc141 slice is built
// from this cell.
//   clk  : rising-edge clock
//   rstn : synchronous active-low reset, loads all zeros
//   d    : next value
//   q    : registered value
module tc141_fflopx #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge clk) begin
        if (!rstn) begin
            q <= '0;
        end else begin
            q <= d;
        end
    end

endmodule

// File: rtl/tc141_satcnt.sv
// tc141_satcnt: saturating up-counter with a synchronous clear.
//   clk   : rising-edge clock
//   rstn  : synchronous active-low reset
//   clr   : clear to zero on the next edge (wins over inc)
//   inc   : add one, holding at all-ones instead of wrapping
//   q     : current count
//   q_inc : q plus inc, saturated (the value the counter would load)
module tc141_satcnt #(
    parameter int CW = 8
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          clr,
    input  logic          inc,
    output logic [CW-1:0] q,
    output logic [CW-1:0] q_inc
);

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v, input logic i);
        if (i && (v != {CW{1'b1}})) begin
            return v + CW'(1);
        end
        return v;
    endfunction

    logic [CW-1:0] d;

    assign q_inc = sat_inc(q, inc);
    assign d     = clr ? '0 : q_inc;

    tc141_fflopx #(.W(CW)) u_cnt (.clk(clk), .rstn(rstn), .d(d), .q(q));

endmodule

// File: rtl/tc141_pulse_acc.sv
// tc141_pulse_acc: counts event pulses over repeating windows of win+1 cycles
// and presents each window's count on a valid/ready output slot. Sits directly
// behind the edge detector; pdin is the detector's single-cycle pulse output.
//   clk     : rising-edge clock
//   rstn    : synchronous active-low reset
//   pdin    : event pulse, one event per high cycle
//   en      : accumulate enable; low returns to IDLE and discards the window
//   win     : window length minus one, latched at each window start
//   clr     : soft clear of ovr and the output slot
//   cnt_vld : window result valid
//   cnt_dat : window event count (saturating)
//   cnt_rdy : consumer ready
//   ovr     : sticky flag, a result was dropped because the slot was full
module tc141_pulse_acc
    import tc141_pkg::*;
#(
    parameter int CW = CW_DEF,
    parameter int TW = TW_DEF
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          pdin,
    input  logic          en,
    input  logic [TW-1:0] win,
    input  logic          clr,
    output logic          cnt_vld,
    output logic [CW-1:0] cnt_dat,
    input  logic          cnt_rdy,
    output logic          ovr
);

    state_t        state;
    state_t        state_nxt;
    logic [0:0]    state_q;
    logic          start;
    logic          active;
    logic          close;

    logic [TW-1:0] timer_q;
    logic [TW-1:0] timer_d;
    logic [TW-1:0] wlen_q;
    logic [TW-1:0] wlen_d;

    logic [CW-1:0] acc_q;
    logic [CW-1:0] res;
    logic          acc_clr;

    logic          vld_q;
    logic          vld_d;
    logic [CW-1:0] dat_q;
    logic [CW-1:0] dat_d;
    logic          ovr_q;
    logic          ovr_d;
    logic          slot_free;

    // ---- control: FSM state register and next-state logic
    tc141_fflopx #(.W(1)) u_state (.clk(clk), .rstn(rstn), .d(state_nxt), .q(state_q));
    assign state = state_t'(state_q);

    always_comb begin
        state_nxt = state;
        start     = 1'b0;
        active    = 1'b0;
        case (state)
            IDLE: begin
                if (en) begin
                    state_nxt = RUN;
                    start     = 1'b1;
                end
            end
            RUN: begin
                if (en) begin
                    active = 1'b1;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign close = active && (timer_q == wlen_q);

    // ---- window timer and length; both restart at every window boundary.
    // Outside an active cycle the timer is held at 0 so a new window always
    // begins at cycle 0 and an aborted window leaves nothing behind.
    assign timer_d = (!active || close) ? '0 : timer_q + TW'(1);
    assign wlen_d  = (start || close) ? win : wlen_q;

    tc141_fflopx #(.W(TW)) u_timer (.clk(clk), .rstn(rstn), .d(timer_d), .q(timer_q));
    tc141_fflopx #(.W(TW)) u_wlen  (.clk(clk), .rstn(rstn), .d(wlen_d),  .q(wlen_q));

    // ---- accumulator; res already includes a pulse on the close cycle
    assign acc_clr = !active || close;

    tc141_satcnt #(.CW(CW)) u_acc (
        .clk   (clk),
        .rstn  (rstn),
        .clr   (acc_clr),
        .inc   (pdin && active),
        .q     (acc_q),
        .q_inc (res)
    );

    // ---- output slot: clr beats close, close beats a plain transfer
    assign slot_free = !vld_q || cnt_rdy;

    always_comb begin
        vld_d = vld_q;
        dat_d = dat_q;
        ovr_d = ovr_q;
        if (clr) begin
            vld_d = 1'b0;
            dat_d = '0;
            ovr_d = 1'b0;
        end else if (close) begin
            if (slot_free) begin
                vld_d = 1'b1;
                dat_d = res;
            end else begin
                ovr_d = 1'b1;
            end
        end else if (vld_q && cnt_rdy) begin
            vld_d = 1'b0;
        end
    end

    tc141_fflopx #(.W(1))  u_vld (.clk(clk), .rstn(rstn), .d(vld_d), .q(vld_q));
    tc141_fflopx #(.W(CW)) u_dat (.clk(clk), .rstn(rstn), .d(dat_d), .q(dat_q));
    tc141_fflopx #(.W(1))  u_ovr (.clk(clk), .rstn(rstn), .d(ovr_d), .q(ovr_q));

    assign cnt_vld = vld_q;
    assign cnt_dat = dat_q;
    assign ovr     = ovr_q;

endmodule

// File: doc/tc141_pulse_acc.md
TC141_PULSE_ACC -- requirements
Module: tc141_pulse_acc

Interface
REQ-001 Parameter CW, default 8: width of the pulse count.
REQ-002 Parameter TW, default 16: width of the window timer and the window-length input.
REQ-003 Port clk  input  1: single clock; all logic is rising-edge clocked.
REQ-004 Port rstn  input  1: reset, synchronous, active-low.
REQ-005 Port pdin  input  1: single-cycle event pulse from the upstream edge detector; each high cycle is one event.
REQ-006 Port en  input  1: accumulate enable; low forces IDLE.
REQ-007 Port win  input  TW: window length; a window lasts win+1 cycles; sampled only when a window starts.
REQ-008 Port clr  input  1: soft clear of the overrun flag and the output register.
REQ-009 Port cnt_vld  output  1: window result valid.
REQ-010 Port cnt_dat  output  CW: event count of the completed window.
REQ-011 Port cnt_rdy  input  1: consumer ready; a transfer occurs when cnt_vld and cnt_rdy are both high.
REQ-012 Port ovr  output  1: sticky overrun flag.

Function
REQ-013 The FSM SHALL have two states, IDLE and RUN.
REQ-014 IDLE -> RUN on the first cycle en=1; RUN -> IDLE on any cycle en=0.
REQ-015 Leaving RUN SHALL discard the partial accumulator and timer without producing a result.
REQ-016 On entry to RUN, the block SHALL latch win into wlen, clear the timer to 0 and clear the accumulator to 0.
REQ-017 The first cycle in RUN is window cycle 0.
REQ-018 In RUN, each cycle with pdin=1 SHALL increment the accumulator.
REQ-019 The accumulator SHALL saturate at 2^CW-1 and not wrap.
REQ-020 In RUN, the timer SHALL increment each cycle; the cycle with timer==wlen is the window-close cycle.
REQ-021 On the window-close cycle, the result SHALL be acc plus pdin, saturating; a pulse on the close cycle counts in the closing window.
REQ-022 On the window-close cycle, the timer and accumulator SHALL reset to 0 and win SHALL be re-latched into wlen; the next cycle is cycle 0 of the next window, with no gap.
REQ-023 If the output slot is free at close (cnt_vld=0, or cnt_vld=1 with cnt_rdy=1), cnt_dat SHALL load the result and cnt_vld SHALL be 1 in the following cycle (1-cycle latency).
REQ-024 If the output slot is occupied at close (cnt_vld=1 and cnt_rdy=0), the new result SHALL be dropped, cnt_dat held and ovr set to 1.
REQ-025 Once cnt_vld is high, cnt_dat SHALL remain stable until the transfer completes.
REQ-026 After a transfer with no coincident close, cnt_vld SHALL fall the next cycle.
REQ-027 When a transfer and a close coincide, cnt_vld SHALL stay 1 with the new data and no overrun.
REQ-028 With wlen=0, every cycle is a close cycle and the result is pdin (0 or 1).
REQ-029 clr=1 SHALL clear ovr, cnt_vld and cnt_dat next cycle.
REQ-030 clr SHALL NOT affect the FSM, timer or accumulator.
REQ-031 clr SHALL take priority over a coincident close; the result of that close is lost without setting ovr.
REQ-032 cnt_rdy SHALL be ignored while cnt_vld=0.

Reset
REQ-033 With rstn=0 sampled on a rising edge: state=IDLE; timer, accumulator and wlen = 0; cnt_vld=0; cnt_dat=0; ovr=0.
REQ-034 Reset SHALL override every other input, including mid-window; no partial result is emitted.
REQ-035 The first window after reset starts on the first cycle with rstn=1 and en=1.

Structure
REQ-036 The shared tc141 package SHALL hold the FSM state encoding and the default CW/TW constants.
REQ-037 All state elements SHALL be implemented with the existing tc141_fflopx register cell.
REQ-038 One sub-module, tc141_satcnt, SHALL be a synchronous-clear saturating counter, used for the accumulator; the timer is inline.
REQ-039 The block SHALL be placed directly downstream of the edge detector, with its pdin driven by the detector's pulse output.

Verification
REQ-040 Basic count: win=9, en=1, pulses in window cycles 2, 5 and 9 -> cnt_vld=1 in cycle 10 with cnt_dat=3; cnt_rdy=1 -> cnt_vld=0 in cycle 11.
REQ-041 Saturation: CW=8, win=299, pdin=1 for all 300 cycles -> cnt_dat=255, no wrap.
REQ-042 Overrun: win=3, cnt_rdy=0, one pulse per window for two windows -> first cnt_dat=1 held; ovr=1 after the second close; clr pulse -> ovr=0, cnt_vld=0.
REQ-043 Coincident transfer and close: win=0, cnt_rdy=1, pdin alternating 1,0,1 -> cnt_vld continuously 1 with cnt_dat 1,0,1 and ovr=0.
REQ-044 Mid-window abort: win=15, 4 pulses, en dropped at cycle 8 -> no cnt_vld; en re-raised -> next window result counts only new pulses.
REQ-045 Reset mid-window: rstn=0 at cycle 6 of a window with cnt_vld=1 -> all outputs 0 next cycle; the window restarts from cycle 0 after release.
